// File: rtl/calc_pkg.sv
// Shared types and PS/2 scan-code constants for the calculator key sequencer.
package calc_pkg;

    typedef enum logic [1:0] {
        ADD = 2'd0,
        SUB = 2'd1,
        MUL = 2'd2,
        DIV = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        DIGIT = 3'd0,
        OP    = 3'd1,
        DEL   = 3'd2,
        CLR   = 3'd3,
        ENT   = 3'd4,
        NONE  = 3'd5
    } key_e;

    typedef enum logic [1:0] {
        S_A    = 2'd0,
        S_B    = 2'd1,
        S_WAIT = 2'd2,
        S_RES  = 2'd3
    } state_e;

    // Classified key: kind plus the digit value or operator it carries
    typedef struct packed {
        key_e       kind;
        logic [3:0] digit;
        op_e        op;
    } key_t;

    localparam logic [7:0] SC_BRK = 8'hF0;
    localparam logic [7:0] SC_EXT = 8'hE0;
    localparam logic [7:0] SC_D0  = 8'h70;
    localparam logic [7:0] SC_D1  = 8'h69;
    localparam logic [7:0] SC_D2  = 8'h72;
    localparam logic [7:0] SC_D3  = 8'h7A;
    localparam logic [7:0] SC_D4  = 8'h6B;
    localparam logic [7:0] SC_D5  = 8'h73;
    localparam logic [7:0] SC_D6  = 8'h74;
    localparam logic [7:0] SC_D7  = 8'h6C;
    localparam logic [7:0] SC_D8  = 8'h75;
    localparam logic [7:0] SC_D9  = 8'h7D;
    localparam logic [7:0] SC_ADD = 8'h79;
    localparam logic [7:0] SC_SUB = 8'h7B;
    localparam logic [7:0] SC_MUL = 8'h7C;
    localparam logic [7:0] SC_DIV = 8'h4A;
    localparam logic [7:0] SC_DEL = 8'h71;
    localparam logic [7:0] SC_CLR = 8'h66;
    localparam logic [7:0] SC_ENT = 8'h5A;

endpackage

// File: rtl/calc_key_classify.sv
// Combinational decode of a raw PS/2 byte into a calculator key class.
module calc_key_classify
    import calc_pkg::*;
(
    input  logic [7:0] i_scan_code,
    output key_t       o_key_c
);

    always_comb begin : classify
        o_key_c.kind  = NONE;
        o_key_c.digit = 4'd0;
        o_key_c.op    = ADD;
        case (i_scan_code)
            SC_D0:  begin o_key_c.kind = DIGIT; o_key_c.digit = 4'd0; end
            SC_D1:  begin o_key_c.kind = DIGIT; o_key_c.digit = 4'd1; end
            SC_D2:  begin o_key_c.kind = DIGIT; o_key_c.digit = 4'd2; end
            SC_D3:  begin o_key_c.kind = DIGIT; o_key_c.digit = 4'd3; end
            SC_D4:  begin o_key_c.kind = DIGIT; o_key_c.digit = 4'd4; end
            SC_D5:  begin o_key_c.kind = DIGIT; o_key_c.digit = 4'd5; end
            SC_D6:  begin o_key_c.kind = DIGIT; o_key_c.digit = 4'd6; end
            SC_D7:  begin o_key_c.kind = DIGIT; o_key_c.digit = 4'd7; end
            SC_D8:  begin o_key_c.kind = DIGIT; o_key_c.digit = 4'd8; end
            SC_D9:  begin o_key_c.kind = DIGIT; o_key_c.digit = 4'd9; end
            SC_ADD: begin o_key_c.kind = OP;    o_key_c.op    = ADD;  end
            SC_SUB: begin o_key_c.kind = OP;    o_key_c.op    = SUB;  end
            SC_MUL: begin o_key_c.kind = OP;    o_key_c.op    = MUL;  end
            SC_DIV: begin o_key_c.kind = OP;    o_key_c.op    = DIV;  end
            SC_DEL: o_key_c.kind = DEL;
            SC_CLR: o_key_c.kind = CLR;
            SC_ENT: o_key_c.kind = ENT;
            default: o_key_c.kind = NONE;
        endcase
    end

endmodule

// File: rtl/calc_key_sequencer.sv
// Turns PS/2 make-codes into BCD operands/operator, runs the ALU req/ack
// handshake and holds the result for display and chaining.
module calc_key_sequencer
    import calc_pkg::*;
#(
    parameter int unsigned DIGITS     = 4,
    parameter int unsigned RES_DIGITS = 8
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              scan_valid,
    input  logic [7:0]                        scan_code,
    input  logic                              calc_ack,
    input  logic [4*RES_DIGITS-1:0]           res_bcd,
    input  logic                              res_err,
    output logic                              calc_req,
    output logic [4*DIGITS-1:0]               opa_bcd,
    output logic [4*DIGITS-1:0]               opb_bcd,
    output op_e                               op,
    output logic [4*RES_DIGITS-1:0]           disp_bcd,
    output logic [$clog2(RES_DIGITS+1)-1:0]   disp_cnt,
    output logic                              disp_err,
    output logic                              busy,
    output logic                              key_evt
);

    localparam int unsigned DIG_W  = 4 * DIGITS;
    localparam int unsigned RES_W  = 4 * RES_DIGITS;
    localparam int unsigned CNT_W  = $clog2(DIGITS + 1);
    localparam int unsigned DCNT_W = $clog2(RES_DIGITS + 1);

    state_e              r_state, w_state_nxt;
    logic [DIG_W-1:0]    r_a, r_b, w_a_nxt, w_b_nxt;
    logic [CNT_W-1:0]    r_cnt_a, r_cnt_b, w_cnt_a_nxt, w_cnt_b_nxt;
    op_e                 r_op, w_op_nxt;
    logic [RES_W-1:0]    r_res, w_res_nxt;
    logic                r_err, w_err_nxt;
    logic                r_brk, r_ext, w_brk_nxt, w_ext_nxt;
    logic                r_wait;
    logic [RES_W-1:0]    r_disp, w_disp_nxt;
    logic [DCNT_W-1:0]   r_disp_cnt, w_disp_cnt_nxt;
    logic                r_disp_err, w_disp_err_nxt;
    logic                r_evt, w_evt;

    key_t                w_key;
    key_e                w_kind;
    logic                w_live;
    logic                w_a_full, w_b_full;
    logic [DIG_W-1:0]    w_a_push, w_b_push;

    // Significant digits of a BCD value, never reported below one
    function automatic logic [DCNT_W-1:0] sig_digits(input logic [RES_W-1:0] v);
        logic [DCNT_W-1:0] n;
        n = DCNT_W'(1);
        for (int i = 0; i < int'(RES_DIGITS); i++) begin
            if (v[4*i +: 4] != 4'd0) n = DCNT_W'(i + 1);
        end
        return n;
    endfunction

    calc_key_classify u_classify (
        .i_scan_code (scan_code),
        .o_key_c     (w_key)
    );

    // A byte is a live key only when it is not a prefix and no break preceded it
    assign w_live   = scan_valid && (scan_code != SC_BRK) && (scan_code != SC_EXT) && !r_brk;
    assign w_kind   = w_live ? w_key.kind : NONE;
    assign w_a_full = (r_cnt_a == CNT_W'(DIGITS));
    assign w_b_full = (r_cnt_b == CNT_W'(DIGITS));
    assign w_a_push = (r_a << 4) | DIG_W'(w_key.digit);
    assign w_b_push = (r_b << 4) | DIG_W'(w_key.digit);

    always_comb begin : prefix_next
        w_brk_nxt = r_brk;
        w_ext_nxt = r_ext;
        if (scan_valid) begin
            if (scan_code == SC_BRK) begin
                w_brk_nxt = 1'b1;
            end else if (scan_code == SC_EXT) begin
                w_ext_nxt = 1'b1;
            end else begin
                w_brk_nxt = 1'b0;
                w_ext_nxt = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin : state_reg
        if (!rst_n) r_state <= S_A;
        else        r_state <= w_state_nxt;
    end

    always_comb begin : next_state
        w_state_nxt = r_state;
        case (r_state)
            S_A: begin
                if (w_kind == OP) w_state_nxt = S_B;
            end
            S_B: begin
                if (w_kind == CLR)                                 w_state_nxt = S_A;
                else if (w_kind == DEL && r_cnt_b == CNT_W'(0))    w_state_nxt = S_A;
                else if (w_kind == ENT && r_cnt_b != CNT_W'(0))    w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (calc_ack) w_state_nxt = S_RES;
            end
            S_RES: begin
                if (w_kind == DIGIT || w_kind == CLR) w_state_nxt = S_A;
                else if (w_kind == OP && !r_err)      w_state_nxt = S_B;
            end
            default: w_state_nxt = S_A;
        endcase
    end

    always_comb begin : outputs_next
        w_a_nxt        = r_a;
        w_b_nxt        = r_b;
        w_cnt_a_nxt    = r_cnt_a;
        w_cnt_b_nxt    = r_cnt_b;
        w_op_nxt       = r_op;
        w_res_nxt      = r_res;
        w_err_nxt      = r_err;
        w_evt          = 1'b0;
        w_disp_nxt     = '0;
        w_disp_cnt_nxt = '0;
        w_disp_err_nxt = 1'b0;

        if (w_kind == CLR && r_state != S_WAIT) begin
            w_a_nxt     = '0;
            w_b_nxt     = '0;
            w_cnt_a_nxt = '0;
            w_cnt_b_nxt = '0;
            w_op_nxt    = ADD;
            w_res_nxt   = '0;
            w_err_nxt   = 1'b0;
            w_evt       = 1'b1;
        end else begin
            case (r_state)
                S_A: begin
                    if (w_kind == DIGIT && !w_a_full) begin
                        w_a_nxt     = w_a_push;
                        w_cnt_a_nxt = r_cnt_a + CNT_W'(1);
                        w_evt       = 1'b1;
                    end else if (w_kind == OP) begin
                        w_op_nxt    = w_key.op;
                        w_b_nxt     = '0;
                        w_cnt_b_nxt = '0;
                        w_evt       = 1'b1;
                    end else if (w_kind == DEL && r_cnt_a != CNT_W'(0)) begin
                        w_a_nxt     = r_a >> 4;
                        w_cnt_a_nxt = r_cnt_a - CNT_W'(1);
                        w_evt       = 1'b1;
                    end
                end
                S_B: begin
                    if (w_kind == DIGIT && !w_b_full) begin
                        w_b_nxt     = w_b_push;
                        w_cnt_b_nxt = r_cnt_b + CNT_W'(1);
                        w_evt       = 1'b1;
                    end else if (w_kind == OP && r_cnt_b == CNT_W'(0)) begin
                        w_op_nxt    = w_key.op;
                        w_evt       = 1'b1;
                    end else if (w_kind == DEL) begin
                        // Deleting from an empty B steps back to editing A
                        if (r_cnt_b != CNT_W'(0)) begin
                            w_b_nxt     = r_b >> 4;
                            w_cnt_b_nxt = r_cnt_b - CNT_W'(1);
                        end
                        w_evt = 1'b1;
                    end else if (w_kind == ENT && r_cnt_b != CNT_W'(0)) begin
                        w_evt = 1'b1;
                    end
                end
                S_WAIT: begin
                    if (calc_ack) begin
                        w_res_nxt = res_bcd;
                        w_err_nxt = res_err;
                    end
                end
                S_RES: begin
                    if (w_kind == DIGIT) begin
                        w_a_nxt     = DIG_W'(w_key.digit);
                        w_cnt_a_nxt = CNT_W'(1);
                        w_b_nxt     = '0;
                        w_cnt_b_nxt = '0;
                        w_op_nxt    = ADD;
                        w_res_nxt   = '0;
                        w_err_nxt   = 1'b0;
                        w_evt       = 1'b1;
                    end else if (w_kind == OP && !r_err) begin
                        w_a_nxt     = r_res[DIG_W-1:0];
                        w_cnt_a_nxt = CNT_W'(DIGITS);
                        w_op_nxt    = w_key.op;
                        w_b_nxt     = '0;
                        w_cnt_b_nxt = '0;
                        w_evt       = 1'b1;
                    end
                end
                default: ;
            endcase
        end

        case (w_state_nxt)
            S_A: begin
                w_disp_nxt     = RES_W'(w_a_nxt);
                w_disp_cnt_nxt = DCNT_W'(w_cnt_a_nxt);
            end
            S_B, S_WAIT: begin
                w_disp_nxt     = RES_W'(w_b_nxt);
                w_disp_cnt_nxt = DCNT_W'(w_cnt_b_nxt);
            end
            default: begin
                w_disp_nxt     = w_res_nxt;
                w_disp_cnt_nxt = sig_digits(w_res_nxt);
                w_disp_err_nxt = w_err_nxt;
            end
        endcase
    end

    always_ff @(posedge clk) begin : data_reg
        if (!rst_n) begin
            r_a        <= '0;
            r_b        <= '0;
            r_cnt_a    <= '0;
            r_cnt_b    <= '0;
            r_op       <= ADD;
            r_res      <= '0;
            r_err      <= 1'b0;
            r_brk      <= 1'b0;
            r_ext      <= 1'b0;
            r_wait     <= 1'b0;
            r_disp     <= '0;
            r_disp_cnt <= '0;
            r_disp_err <= 1'b0;
            r_evt      <= 1'b0;
        end else begin
            r_a        <= w_a_nxt;
            r_b        <= w_b_nxt;
            r_cnt_a    <= w_cnt_a_nxt;
            r_cnt_b    <= w_cnt_b_nxt;
            r_op       <= w_op_nxt;
            r_res      <= w_res_nxt;
            r_err      <= w_err_nxt;
            r_brk      <= w_brk_nxt;
            r_ext      <= w_ext_nxt;
            r_wait     <= (w_state_nxt == S_WAIT);
            r_disp     <= w_disp_nxt;
            r_disp_cnt <= w_disp_cnt_nxt;
            r_disp_err <= w_disp_err_nxt;
            r_evt      <= w_evt;
        end
    end

    assign calc_req = r_wait;
    assign busy     = r_wait;
    assign opa_bcd  = r_a;
    assign opb_bcd  = r_b;
    assign op       = r_op;
    assign disp_bcd = r_disp;
    assign disp_cnt = r_disp_cnt;
    assign disp_err = r_disp_err;
    assign key_evt  = r_evt;

endmodule

// File: tb/tb_calc_key_sequencer.sv
// Directed, table-driven bench for calc_key_sequencer with hand-computed expectations.
module tb_calc_key_sequencer;
    import calc_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        scan_valid = 1'b0;
    logic [7:0]  scan_code = 8'h00;
    logic        calc_ack = 1'b0;
    logic [31:0] res_bcd = 32'h0;
    logic        res_err = 1'b0;
    logic        calc_req;
    logic [15:0] opa_bcd, opb_bcd;
    op_e         op;
    logic [31:0] disp_bcd;
    logic [3:0]  disp_cnt;
    logic        disp_err, busy, key_evt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    calc_key_sequencer #(.DIGITS(4), .RES_DIGITS(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .scan_valid (scan_valid),
        .scan_code  (scan_code),
        .calc_ack   (calc_ack),
        .res_bcd    (res_bcd),
        .res_err    (res_err),
        .calc_req   (calc_req),
        .opa_bcd    (opa_bcd),
        .opb_bcd    (opb_bcd),
        .op         (op),
        .disp_bcd   (disp_bcd),
        .disp_cnt   (disp_cnt),
        .disp_err   (disp_err),
        .busy       (busy),
        .key_evt    (key_evt)
    );

    typedef struct {
        logic [7:0]  code;
        logic        evt;
        logic [31:0] disp;
        logic [3:0]  cnt;
        logic [15:0] opa;
        logic [1:0]  opc;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [7:0] c, input logic e, input logic [31:0] d,
                       input logic [3:0] n, input logic [15:0] a, input logic [1:0] o);
        vec_t v;
        v.code = c; v.evt = e; v.disp = d; v.cnt = n; v.opa = a; v.opc = o;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at a falling edge; returns at the next falling edge with the key's effect visible
    task automatic send(input logic [7:0] c);
        scan_valid = 1'b1;
        scan_code  = c;
        @(negedge clk);
        scan_valid = 1'b0;
    endtask

    task automatic ack(input logic [31:0] r, input logic e);
        calc_ack = 1'b1;
        res_bcd  = r;
        res_err  = e;
        @(negedge clk);
        calc_ack = 1'b0;
    endtask

    int req_cycles;

    initial begin
        // code, evt, disp, cnt, opa, op
        add(8'h69, 1, 32'h1,    1, 16'h1,    2'd0);
        add(8'hF0, 0, 32'h1,    1, 16'h1,    2'd0);
        add(8'h69, 0, 32'h1,    1, 16'h1,    2'd0);
        add(8'h72, 1, 32'h12,   2, 16'h12,   2'd0);
        add(8'hF0, 0, 32'h12,   2, 16'h12,   2'd0);
        add(8'h72, 0, 32'h12,   2, 16'h12,   2'd0);
        add(8'h7A, 1, 32'h123,  3, 16'h123,  2'd0);
        add(8'h6B, 1, 32'h1234, 4, 16'h1234, 2'd0);
        add(8'h73, 0, 32'h1234, 4, 16'h1234, 2'd0);
        add(8'h71, 1, 32'h123,  3, 16'h123,  2'd0);
        add(8'h55, 0, 32'h123,  3, 16'h123,  2'd0);
        add(8'h66, 1, 32'h0,    0, 16'h0,    2'd0);
        add(8'h5A, 0, 32'h0,    0, 16'h0,    2'd0);
        add(8'h71, 0, 32'h0,    0, 16'h0,    2'd0);
        add(8'h79, 1, 32'h0,    0, 16'h0,    2'd0);
        add(8'h7C, 1, 32'h0,    0, 16'h0,    2'd2);
        add(8'h5A, 0, 32'h0,    0, 16'h0,    2'd2);
        add(8'h71, 1, 32'h0,    0, 16'h0,    2'd2);
        add(8'h66, 1, 32'h0,    0, 16'h0,    2'd0);
        add(8'h7D, 1, 32'h9,    1, 16'h9,    2'd0);
        add(8'h70, 1, 32'h90,   2, 16'h90,   2'd0);
        add(8'hE0, 0, 32'h90,   2, 16'h90,   2'd0);
        add(8'h75, 1, 32'h908,  3, 16'h908,  2'd0);
        add(8'h66, 1, 32'h0,    0, 16'h0,    2'd0);

        // Reset
        repeat (2) @(negedge clk);
        chk("rst_req",  32'(calc_req), 32'd0);
        chk("rst_busy", 32'(busy),     32'd0);
        chk("rst_disp", disp_bcd,      32'd0);
        chk("rst_cnt",  32'(disp_cnt), 32'd0);
        chk("rst_opa",  32'(opa_bcd),  32'd0);
        chk("rst_evt",  32'(key_evt),  32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Entry table
        for (int i = 0; i < vecs.size(); i++) begin
            send(vecs[i].code);
            chk($sformatf("v%0d_evt", i),  32'(key_evt),  32'(vecs[i].evt));
            chk($sformatf("v%0d_disp", i), disp_bcd,      vecs[i].disp);
            chk($sformatf("v%0d_cnt", i),  32'(disp_cnt), 32'(vecs[i].cnt));
            chk($sformatf("v%0d_opa", i),  32'(opa_bcd),  32'(vecs[i].opa));
            chk($sformatf("v%0d_op", i),   32'(op),       32'(vecs[i].opc));
            chk($sformatf("v%0d_busy", i), 32'(busy),     32'd0);
        end

        // 12 + 3 with a slow ALU
        send(8'h69); send(8'h72); send(8'h79); send(8'h7A); send(8'h5A);
        chk("add_req",  32'(calc_req), 32'd1);
        chk("add_busy", 32'(busy),     32'd1);
        chk("add_opa",  32'(opa_bcd),  32'h12);
        chk("add_opb",  32'(opb_bcd),  32'h3);
        chk("add_op",   32'(op),       32'(ADD));
        req_cycles = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (calc_req) req_cycles++;
        end
        chk("add_req_held", 32'(req_cycles), 32'd5);
        send(8'h66);
        chk("wait_clr_evt", 32'(key_evt), 32'd0);
        chk("wait_clr_opb", 32'(opb_bcd), 32'h3);
        chk("wait_clr_req", 32'(calc_req), 32'd1);
        ack(32'h15, 1'b0);
        chk("res_req",  32'(calc_req), 32'd0);
        chk("res_busy", 32'(busy),     32'd0);
        chk("res_disp", disp_bcd,      32'h15);
        chk("res_cnt",  32'(disp_cnt), 32'd2);
        chk("res_err",  32'(disp_err), 32'd0);

        // Chain from result, then reset mid-transaction
        send(8'h7B);
        chk("chain_evt", 32'(key_evt), 32'd1);
        chk("chain_opa", 32'(opa_bcd), 32'h15);
        chk("chain_cnt", 32'(disp_cnt), 32'd0);
        send(8'h69); send(8'h5A);
        chk("chain_req", 32'(calc_req), 32'd1);
        chk("chain_opb", 32'(opb_bcd), 32'h1);
        chk("chain_op",  32'(op),      32'(SUB));
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_req",  32'(calc_req), 32'd0);
        chk("mid_rst_opa",  32'(opa_bcd),  32'd0);
        chk("mid_rst_disp", disp_bcd,      32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Stray ack outside S_WAIT
        ack(32'h99, 1'b1);
        chk("stray_ack_disp", disp_bcd,      32'd0);
        chk("stray_ack_err",  32'(disp_err), 32'd0);
        chk("stray_ack_req",  32'(calc_req), 32'd0);

        // Extended divide with error result
        send(8'h69); send(8'hE0); send(8'h4A); send(8'h72); send(8'hE0); send(8'h5A);
        chk("div_op",  32'(op),       32'(DIV));
        chk("div_opb", 32'(opb_bcd),  32'h2);
        chk("div_req", 32'(calc_req), 32'd1);
        ack(32'h0, 1'b1);
        chk("div_err", 32'(disp_err), 32'd1);
        chk("div_cnt", 32'(disp_cnt), 32'd1);
        send(8'h7B);
        chk("err_op_evt", 32'(key_evt),  32'd0);
        chk("err_op_err", 32'(disp_err), 32'd1);
        send(8'h66);
        chk("err_clr_evt", 32'(key_evt),  32'd1);
        chk("err_clr_err", 32'(disp_err), 32'd0);
        chk("err_clr_opa", 32'(opa_bcd),  32'd0);
        chk("err_clr_opb", 32'(opb_bcd),  32'd0);
        chk("err_clr_op",  32'(op),       32'd0);
        chk("err_clr_cnt", 32'(disp_cnt), 32'd0);

        // Result with inner zeros, then a digit starts fresh
        send(8'h69); send(8'h7C); send(8'h69); send(8'h5A);
        ack(32'h300, 1'b0);
        chk("r300_disp", disp_bcd,      32'h300);
        chk("r300_cnt",  32'(disp_cnt), 32'd3);
        send(8'h7A);
        chk("fresh_disp", disp_bcd,      32'h3);
        chk("fresh_cnt",  32'(disp_cnt), 32'd1);
        chk("fresh_opa",  32'(opa_bcd),  32'h3);
        chk("fresh_op",   32'(op),       32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/calc_key_sequencer.md
Name: calc_key_sequencer

Overview:
Sequences PS/2 make-codes from the keyboard receiver into calculator operations. Tracks break (F0) and extended (E0) prefixes, and builds BCD operand A, the operator, and operand B. On Enter it issues a req/ack transaction to the arithmetic unit, then holds the result for display and for chaining into the next operation. Sits between the PS/2 receiver and both the calculator ALU and the 7-segment display driver.

Parameters:
DIGITS, 4, max decimal digits per operand entry
RES_DIGITS, 8, BCD digits of result/display bus (≥ DIGITS)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
scan_valid  in  1  one-cycle strobe, scan_code valid
scan_code  in  8  raw PS/2 byte
calc_ack  in  1  ALU done; res_bcd/res_err valid same cycle
res_bcd  in  4*RES_DIGITS  ALU result, BCD
res_err  in  1  ALU error (div by zero, overflow)
calc_req  out  1  compute request, held until ack
opa_bcd  out  4*DIGITS  operand A
opb_bcd  out  4*DIGITS  operand B
op  out  2  operator code (package enum)
disp_bcd  out  4*RES_DIGITS  current entry or result, zero-extended
disp_cnt  out  $clog2(RES_DIGITS+1)  significant digits shown
disp_err  out  1  result error flag
busy  out  1  high in S_WAIT
key_evt  out  1  one-cycle pulse per accepted key

Behaviour:
- Reset (clk edge with rst_n=0): state S_A; every output and register 0; brk/ext flags clear. Reset in S_WAIT drops calc_req on the next edge.
- Prefixes: F0 sets brk; E0 sets ext. The next non-prefix byte clears both flags. If brk was set, that byte is discarded. The ext flag does not change key meaning (E0 4A = divide, E0 5A = Enter). Repeated make codes count as repeated presses.
- Key classes: digits 70,69,72,7A,6B,73,74,6C,75,7D → 0..9; 79 ADD; 7B SUB; 7C MUL; 4A DIV; 71 DEL; 66 CLR; 5A ENT. Any other code is ignored with no key_evt.
- All updates are registered. A key at cycle n is visible at n+1. key_evt pulses at n+1 only when the key is accepted.
- S_A (entering A):
  - digit: if cnt_a<DIGITS, A={A<<4 | d} and cnt_a++; else ignored.
  - op: latch op, B=0, cnt_b=0, go to S_B. Empty A counts as 0.
  - DEL: if cnt_a>0, A>>=4 and cnt_a--.
  - ENT: ignored.
- S_B (entering B):
  - digit: same rules as S_A, applied to B.
  - op: replaces op if cnt_b==0; ignored otherwise.
  - DEL: if cnt_b>0, shift right and decrement; if cnt_b==0, return to S_A with A intact.
  - ENT: if cnt_b>0, go to S_WAIT and assert calc_req next cycle; ignored if cnt_b==0.
- S_WAIT:
  - calc_req=1. opa_bcd, opb_bcd and op are stable.
  - All keys are dropped, CLR included, and prefix flags are still tracked.
  - On calc_ack: latch res_bcd and res_err, deassert calc_req next cycle, go to S_RES.
  - calc_ack outside S_WAIT is ignored.
- S_RES (showing result):
  - digit: clear, A=d, cnt_a=1, go to S_A.
  - op: if !err, A=low DIGITS digits of result, cnt_a=DIGITS, go to S_B; if err, ignored.
  - DEL and ENT: ignored.
- CLR in S_A, S_B or S_RES: clear A, B, op, result and err; go to S_A.
- Display:
  - S_A shows A with cnt_a; S_B shows B with cnt_b (cnt 0 is allowed).
  - S_WAIT shows B.
  - S_RES shows the result, disp_err=err, and disp_cnt = digits excluding leading zeros, minimum 1.

Decomposition:
- Package calc_pkg holds:
  - op_e: ADD=0, SUB=1, MUL=2, DIV=3.
  - key_e: DIGIT, OP, DEL, CLR, ENT, NONE.
  - state_e: S_A, S_B, S_WAIT, S_RES.
  - Scan-code constants, including F0 and E0.
- Sub-module calc_key_classify: combinational scan_code → {key_e, digit[3:0], op_e}. The sequencer FSM and the BCD shift registers stay in calc_key_sequencer.

Test Plan:
1. Reset: rst_n=0 for 2 cycles, then 1 → all outputs 0, state S_A, disp_cnt=0.
2. Press 1 then 2 with releases (69,F0,69,72,F0,72) → disp_bcd=0x00000012, disp_cnt=2, key_evt exactly twice.
3. Enter 12+3 (69,72,79,7A,5A), hold calc_ack low 5 cycles → calc_req=1 throughout with opa=0x0012, opb=0x0003, op=ADD. Then calc_ack with res_bcd=0x15 → calc_req=0 next cycle, disp=0x15, disp_cnt=2, busy=0.
4. Digit overflow and delete (69,72,7A,6B,73, then 71) → opa=0x1234 after the fifth digit, which is ignored. After 71: 0x0123, cnt_a=3.
5. Extended divide, clear, error (69,E0,4A,72,E0,5A; ack with res_err=1) → op=DIV, opb=0x0002, disp_err=1. A following 7B is ignored; 66 returns to S_A with everything 0.
6. Chaining and reset mid-transaction:
   - After result 0x15 in S_RES, 7B,69,5A → opa=0x0015, opb=0x0001, op=SUB, calc_req=1.
   - rst_n=0 during that S_WAIT → calc_req=0 next cycle, state S_A.
